// File: rtl/nibble_serial_subtractor16_if.sv
// nibble_serial_subtractor16_if: operand/result handshake bundle (master drives in_valid,a,b,bin,out_ready; slave drives in_ready,out_valid,diff,bout,ovf)
interface nibble_serial_subtractor16_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  modport master (output in_valid, a, b, bin, out_ready, input in_ready, out_valid, diff, bout, ovf);
  modport slave  (input in_valid, a, b, bin, out_ready, output in_ready, out_valid, diff, bout, ovf);
endinterface

// File: rtl/nibble_serial_subtractor16.sv
// nibble_serial_subtractor16: 16-bit a-b-bin, one 4-bit lookahead slice per cycle; ports clk, rst (sync active-high), bus (slave handshake bundle)
module nibble_serial_subtractor16 (
  input logic                          clk,
  input logic                          rst,
  nibble_serial_subtractor16_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t      state_q, state_d;
  logic [1:0]  idx_q;
  logic        brw_q;
  logic [15:0] a_q, b_q, diff_q;
  logic        bout_q, ovf_q;
  logic [3:0]  an, bn, g, p, lb, nd;
  // lb[i] is the borrow out of bit i, each term flattened so the slice has no ripple
  always_comb begin
    an = a_q[{idx_q, 2'b00} +: 4];
    bn = b_q[{idx_q, 2'b00} +: 4];
    g  = ~an & bn;
    p  = ~(an ^ bn);
    lb[0] = g[0] | p[0] & brw_q;
    lb[1] = g[1] | p[1] & g[0] | (&p[1:0]) & brw_q;
    lb[2] = g[2] | p[2] & g[1] | (&p[2:1]) & g[0] | (&p[2:0]) & brw_q;
    lb[3] = g[3] | p[3] & g[2] | (&p[3:2]) & g[1] | (&p[3:1]) & g[0] | (&p) & brw_q;
    nd = an ^ bn ^ {lb[2:0], brw_q};
  end
  always_comb begin
    state_d = state_q == IDLE ? (bus.in_valid ? CALC : IDLE) :
              state_q == CALC ? (idx_q == 2'd3 ? DONE : CALC) :
              (bus.out_ready ? IDLE : DONE);
  end
  // bin is loaded into the running borrow so nibble 0 sees it as its slice borrow-in
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      brw_q   <= 1'b0;
      diff_q  <= 16'd0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.in_valid) begin
        a_q   <= bus.a;
        b_q   <= bus.b;
        brw_q <= bus.bin;
        idx_q <= 2'd0;
      end
      if (state_q == CALC) begin
        diff_q[{idx_q, 2'b00} +: 4] <= nd;
        brw_q <= lb[3];
        idx_q <= idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          bout_q <= lb[3];
          ovf_q  <= (a_q[15] ^ b_q[15]) & (a_q[15] ^ nd[3]);
        end
      end
    end
  end
  assign bus.in_ready  = state_q == IDLE && !rst;
  assign bus.out_valid = state_q == DONE && !rst;
  assign bus.diff      = diff_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_nibble_serial_subtractor16.sv
// tb_nibble_serial_subtractor16: directed and random checks of the serial subtractor against an arithmetic model
module tb_nibble_serial_subtractor16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  nibble_serial_subtractor16_if bus ();
  nibble_serial_subtractor16 dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one operation, check latency and the result against plain arithmetic; leaves it in DONE
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bn);
    int n;
    int sd;
    logic [15:0] ed;
    logic eb, eo;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk("in_ready_wait", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.bin = bn;
    tick();
    bus.in_valid = 1'b0;
    bus.a = 16'($urandom);
    bus.b = 16'($urandom);
    bus.bin = 1'($urandom);
    for (int k = 0; k < 4; k++) begin
      chk("calc_out_valid_low", bus.out_valid, 0);
      tick();
    end
    ed = a - b - 16'(bn);
    eb = int'(a) < int'(b) + int'(bn);
    sd = int'($signed(a)) - int'($signed(b)) - int'(bn);
    eo = sd > 32767 || sd < -32768;
    chk("out_valid_at_4", bus.out_valid, 1);
    chk("diff", bus.diff, ed);
    chk("bout", bus.bout, eb);
    chk("ovf", bus.ovf, eo);
  endtask

  task automatic consume(input int delay);
    for (int k = 0; k < delay; k++) begin
      tick();
      chk("done_hold", bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("after_consume_valid", bus.out_valid, 0);
    chk("after_consume_ready", bus.in_ready, 1);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.a = 16'd0;
    bus.b = 16'd0;
    bus.bin = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_diff", bus.diff, 0);
    chk("rst_bout", bus.bout, 0);
    chk("rst_ovf", bus.ovf, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1);
    do_op(16'h1234, 16'h0234, 1'b0);
    chk("v1_diff", bus.diff, 16'h1000);
    // backpressure with new operands offered while DONE
    bus.in_valid = 1'b1;
    bus.a = 16'hFFFF;
    bus.b = 16'h0001;
    bus.bin = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_diff", bus.diff, 16'h1000);
      chk("bp_bout", bus.bout, 0);
      chk("bp_ovf", bus.ovf, 0);
    end
    bus.in_valid = 1'b0;
    consume(0);
    chk("retain_diff", bus.diff, 16'h1000);
    do_op(16'h0000, 16'h0001, 1'b0);
    chk("v2_diff", bus.diff, 16'hFFFF);
    chk("v2_bout", bus.bout, 1);
    consume(1);
    do_op(16'h8000, 16'h0001, 1'b0);
    chk("v3_ovf", bus.ovf, 1);
    consume(0);
    do_op(16'h7FFF, 16'hFFFF, 1'b0);
    chk("v4_diff", bus.diff, 16'h8000);
    chk("v4_ovf", bus.ovf, 1);
    consume(2);
    do_op(16'h0010, 16'h000F, 1'b1);
    chk("v5_diff", bus.diff, 16'h0000);
    consume(0);
    do_op(16'hABCD, 16'hABCD, 1'b0);
    consume(0);
    do_op(16'hABCD, 16'hABCD, 1'b1);
    consume(0);
    do_op(16'h0000, 16'hFFFF, 1'b1);
    consume(0);
    // reset in CALC at nibble index 2
    bus.in_valid = 1'b1;
    bus.a = 16'hFFFF;
    bus.b = 16'h1111;
    bus.bin = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_calc_in_ready", bus.in_ready, 0);
    tick();
    chk("rst_calc_valid", bus.out_valid, 0);
    chk("rst_calc_diff", bus.diff, 0);
    chk("rst_calc_bout", bus.bout, 0);
    chk("rst_calc_ovf", bus.ovf, 0);
    rst = 1'b0;
    #1;
    chk("rst_calc_ready", bus.in_ready, 1);
    do_op(16'd5, 16'd3, 1'b0);
    chk("v6_diff", bus.diff, 16'h0002);
    consume(0);
    for (int r = 0; r < 40; r++) begin
      do_op(16'($urandom), 16'($urandom), 1'($urandom));
      consume(int'($urandom_range(0, 2)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
